// File: rtl/spi_master_if.sv
// SPI master bus: host-side handshake plus the four serial wires.
// The master modport is the spi_master view; the slave modport is the host/peripheral view.
interface spi_master_if #(
  parameter int unsigned DATA_LENGTH = 8
);
  logic                   start;
  logic [DATA_LENGTH-1:0] tx_data;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   busy;
  logic                   done;
  logic                   SCLK;
  logic                   MOSI;
  logic                   MISO;
  logic                   SS;

  modport master (
    input  start, tx_data, MISO,
    output rx_data, busy, done, SCLK, MOSI, SS
  );

  modport slave (
    output start, tx_data, MISO,
    input  rx_data, busy, done, SCLK, MOSI, SS
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one frame per accepted start.
// Each non-idle state lasts CLK_DIV clk cycles; SCLK/MOSI/SS and all handshake outputs are registered.
// Optional feature macro: SPI_MASTER_BURST_EN -- when defined, a start seen at the end of HOLD
// chains the next frame directly (SS stays low, GAP skipped).
module spi_master #(
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_LENGTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_LENGTH-1:0] tx_sr;
  logic [DATA_LENGTH-1:0] rx_sr;
  logic                   phase_end;

  // Last clk cycle of the current CLK_DIV-long state.
  assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));

  // Frame sequencer: state, phase counter, shift registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.rx_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.SCLK    <= 1'b0;
      bus.MOSI    <= 1'b0;
      bus.SS      <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (bus.start) begin
          tx_sr    <= bus.tx_data;
          bus.MOSI <= bus.tx_data[DATA_LENGTH-1];
          bus.SS   <= 1'b0;
          bus.busy <= 1'b1;
          bit_cnt  <= '0;
          state    <= SETUP;
        end
      end else if (!phase_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          // Rising SCLK: the slave's bit has been stable for a full low phase.
          SETUP, LOW: begin
            bus.SCLK <= 1'b1;
            rx_sr    <= {rx_sr[DATA_LENGTH-2:0], bus.MISO};
            bit_cnt  <= bit_cnt + 1'b1;
            state    <= HIGH;
          end
          // Falling SCLK: present the next bit, or park in HOLD after the last one.
          HIGH: begin
            bus.SCLK <= 1'b0;
            if (bit_cnt == BIT_W'(DATA_LENGTH)) begin
              state <= HOLD;
            end else begin
              tx_sr    <= tx_sr << 1;
              bus.MOSI <= tx_sr[DATA_LENGTH-2];
              state    <= LOW;
            end
          end
          // Frame complete: publish the received word and either chain or release SS.
          HOLD: begin
            bus.rx_data <= rx_sr;
            bus.done    <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            if (bus.start) begin
              tx_sr    <= bus.tx_data;
              bus.MOSI <= bus.tx_data[DATA_LENGTH-1];
              bit_cnt  <= '0;
              state    <= SETUP;
            end else begin
              bus.SS   <= 1'b1;
              bus.MOSI <= 1'b0;
              state    <= GAP;
            end
`else
            bus.SS   <= 1'b1;
            bus.MOSI <= 1'b0;
            state    <= GAP;
`endif
          end
          GAP: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (DATA_LENGTH=8, CLK_DIV=2) with a mode-0 slave model
// and a scoreboard: stimulus pushes expected frames, a monitor pops them on each done pulse.
module tb_spi_master;
  localparam int unsigned DL = 8;
  localparam int unsigned CD = 2;
  localparam int DONE_LAT = (2 * DL + 1) * CD;
  localparam int BUSY_LAT = (2 * DL + 2) * CD;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t exp_q[$];

  // Monitor-owned state (also read by stimulus for synchronisation).
  int   mon_rises;
  int   ss_run;
  int   frames_seen;
  bit   proto_bad;
  logic prev_sclk;
  logic prev_ss;

  // Slave model state.
  logic       slave_mode;
  logic [7:0] slave_byte;
  logic [7:0] slave_sr;
  logic [7:0] slave_cap;
  logic       slave_miso;
  logic       s_prev_ss;
  logic       s_prev_sclk;

  spi_master_if #(.DATA_LENGTH(DL)) bus ();

  spi_master #(.DATA_LENGTH(DL), .CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.MISO = slave_mode ? slave_miso : bus.MOSI;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: loads on SS fall, captures MOSI on SCLK rise, shifts MISO on SCLK fall.
  always @(negedge clk) begin
    if (rst) begin
      s_prev_ss   <= 1'b1;
      s_prev_sclk <= 1'b0;
      slave_miso  <= 1'b0;
      slave_sr    <= '0;
      slave_cap   <= '0;
    end else begin
      if (!bus.SS && s_prev_ss) begin
        slave_sr   <= slave_byte;
        slave_miso <= slave_byte[7];
      end else if (!bus.SCLK && s_prev_sclk) begin
        slave_sr   <= slave_sr << 1;
        slave_miso <= slave_sr[6];
      end
      if (bus.SCLK && !s_prev_sclk) slave_cap <= {slave_cap[6:0], bus.MOSI};
      s_prev_ss   <= bus.SS;
      s_prev_sclk <= bus.SCLK;
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_rises   = 0;
        ss_run      = 0;
        frames_seen = 0;
        proto_bad   = 1'b0;
        prev_sclk   = 1'b0;
        prev_ss     = 1'b1;
      end else begin
        if (bus.SCLK && !prev_sclk) mon_rises++;
        if (bus.SS && (bus.SCLK || bus.MOSI)) proto_bad = 1'b1;
        if (bus.SS) begin
          ss_run++;
        end else if (prev_ss) begin
          if (frames_seen > 0) chk(ss_run >= CD, "ss_high_gap", ss_run, CD);
          ss_run = 0;
        end
        if (bus.done) begin
          chk(exp_q.size() > 0, "done_expected", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(bus.rx_data == e.rx, "rx_data", int'(bus.rx_data), int'(e.rx));
            chk(cyc == e.done_cyc, "done_latency", cyc, e.done_cyc);
            chk(mon_rises == DL, "sclk_rises", mon_rises, DL);
            chk(slave_cap == e.tx, "mosi_bits", int'(slave_cap), int'(e.tx));
            chk(!proto_bad, "ss_idle_lines", int'(proto_bad), 0);
          end
          mon_rises = 0;
          proto_bad = 1'b0;
          frames_seen++;
        end
        prev_sclk = bus.SCLK;
        prev_ss   = bus.SS;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(!bus.busy, "idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic wait_busy_fall(input int acc, input int lat);
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(!bus.busy && cyc == acc + lat, "busy_fall", cyc, acc + lat);
  endtask

  // One non-burst frame; optional stray start 5 cycles in that must be ignored.
  task automatic run_frame(input logic [7:0] tx, input bit mode, input logic [7:0] sb,
                           input bit poke);
    int   acc;
    exp_t e;
    wait_idle();
    slave_mode  = mode;
    slave_byte  = sb;
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(negedge clk);
    acc        = cyc;
    bus.start  = 1'b0;
    e.rx       = mode ? sb : tx;
    e.tx       = tx;
    e.done_cyc = acc + DONE_LAT;
    exp_q.push_back(e);
    if (poke) begin
      repeat (4) @(negedge clk);
      bus.tx_data = 8'hFF;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.tx_data = tx;
    end
    wait_busy_fall(acc, BUSY_LAT);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_test();
    int n = 0;
    run_frame(8'h00, 1'b0, 8'h00, 1'b0);
    slave_mode  = 1'b0;
    bus.tx_data = 8'hC3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (mon_rises < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(mon_rises >= 3, "abort_sync", mon_rises, 3);
    rst = 1'b1;
    #1;
    chk(bus.SS == 1'b1, "abort_ss", int'(bus.SS), 1);
    chk(bus.SCLK == 1'b0, "abort_sclk", int'(bus.SCLK), 0);
    chk(bus.MOSI == 1'b0, "abort_mosi", int'(bus.MOSI), 0);
    chk(bus.busy == 1'b0, "abort_busy", int'(bus.busy), 0);
    chk(bus.done == 1'b0, "abort_done", int'(bus.done), 0);
    chk(bus.rx_data == 8'h00, "abort_rx_data", int'(bus.rx_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(8'h5A, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic back_to_back_test();
    int   acc1;
    int   acc2;
    exp_t e;
`ifdef SPI_MASTER_BURST_EN
    int ss_hi  = 0;
    int idle_n = 0;
    wait_idle();
    slave_mode  = 1'b0;
    bus.tx_data = 8'h12;
    bus.start   = 1'b1;
    @(negedge clk);
    acc1       = cyc;
    e.rx       = 8'h12;
    e.tx       = 8'h12;
    e.done_cyc = acc1 + DONE_LAT;
    exp_q.push_back(e);
    bus.tx_data = 8'h34;
    acc2        = acc1 + DONE_LAT;
    e.rx        = 8'h34;
    e.tx        = 8'h34;
    e.done_cyc  = acc2 + DONE_LAT;
    exp_q.push_back(e);
    repeat (2 * DONE_LAT - 1) begin
      @(negedge clk);
      if (bus.SS) ss_hi++;
      if (!bus.busy) idle_n++;
      if (cyc == acc2) bus.start = 1'b0;
    end
    chk(ss_hi == 0, "burst_ss_low", ss_hi, 0);
    chk(idle_n == 0, "burst_busy_high", idle_n, 0);
    wait_busy_fall(acc2, BUSY_LAT);
`else
    int n = 0;
    wait_idle();
    slave_mode  = 1'b0;
    bus.tx_data = 8'h12;
    bus.start   = 1'b1;
    @(negedge clk);
    acc1       = cyc;
    e.rx       = 8'h12;
    e.tx       = 8'h12;
    e.done_cyc = acc1 + DONE_LAT;
    exp_q.push_back(e);
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(cyc == acc1 + BUSY_LAT, "held_start_busy_fall", cyc, acc1 + BUSY_LAT);
    bus.tx_data = 8'h34;
    @(negedge clk);
    acc2        = cyc;
    bus.start   = 1'b0;
    chk(acc2 == acc1 + BUSY_LAT + 1, "held_start_reaccept", acc2, acc1 + BUSY_LAT + 1);
    e.rx       = 8'h34;
    e.tx       = 8'h34;
    e.done_cyc = acc2 + DONE_LAT;
    exp_q.push_back(e);
    wait_busy_fall(acc2, BUSY_LAT);
`endif
  endtask

  task automatic stimulus();
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    slave_mode  = 1'b0;
    slave_byte  = '0;
    @(negedge clk);
    chk(bus.SS == 1'b1, "reset_ss", int'(bus.SS), 1);
    chk(bus.SCLK == 1'b0, "reset_sclk", int'(bus.SCLK), 0);
    chk(bus.MOSI == 1'b0, "reset_mosi", int'(bus.MOSI), 0);
    chk(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
    chk(bus.done == 1'b0, "reset_done", int'(bus.done), 0);
    chk(bus.rx_data == 8'h00, "reset_rx_data", int'(bus.rx_data), 0);
    do_reset();

    run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    run_frame(8'h81, 1'b1, 8'h3C, 1'b0);
    run_frame(8'h96, 1'b0, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    chk(bus.rx_data == 8'h96, "rx_data_held", int'(bus.rx_data), 8'h96);
    abort_test();
    back_to_back_test();

    for (int i = 0; i < 14; i++) begin
      logic [7:0] tx;
      logic [7:0] sb;
      bit         mode;
      tx   = 8'($urandom);
      sb   = 8'($urandom);
      mode = 1'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(tx, mode, sb, 1'($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    chk(exp_q.size() == 0, "pending_frames", exp_q.size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fork
      monitor_loop();
      stimulus();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
